// File: rtl/four_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Trial subtraction is an add of the inverted divisor with carry-in 1, like the adder/subtractor.
module four_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] shq_reg;
  logic [WIDTH-1:0] dvsr_reg;
  logic [CW-1:0]    count;

  logic             accept;
  logic             last;
  logic             no_borrow;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_new;
  logic [WIDTH-1:0] shq_new;

  // Requests are only honoured when no division is running.
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (count == '0);
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

  // One restoring step: shift {R,Q}, try R - divisor, keep it only without a borrow.
  always_comb begin
    rem_shift = {rem_reg[WIDTH-1:0], shq_reg[WIDTH-1]};
    trial     = rem_shift + ~{1'b0, dvsr_reg} + ONE;
    no_borrow = ~trial[WIDTH];
    rem_new   = no_borrow ? trial : rem_shift;
    shq_new   = {shq_reg[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (last) state_next = DONE;
      DONE:    state_next = accept ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg     <= '0;
      shq_reg     <= '0;
      dvsr_reg    <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      rem_reg  <= '0;
      shq_reg  <= dividend;
      dvsr_reg <= divisor;
      count    <= CW'(WIDTH - 1);
    end else if (state == CALC) begin
      rem_reg <= rem_new;
      shq_reg <= shq_new;
      if (last) begin
        quotient    <= shq_new;
        remainder   <= rem_new[WIDTH-1:0];
        div_by_zero <= (dvsr_reg == '0);
      end else begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_four_divider.sv
// Self-checking bench for four_divider: spec vectors, handshake corner cases,
// exhaustive sweep and random operations against an arithmetic reference model.
module tb_four_divider;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int total = 0;
  int bad = 0;
  int doneCount = 0;
  int overlapCount = 0;
  int cycle = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
  } vec_t;

  vec_t vecs[6];

  four_divider #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle++;
    #1;
    if (done) doneCount++;
    if (done && busy) overlapCount++;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic refDiv(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << WIDTH) - 1;
      r = a;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endtask

  // Pulses start for one cycle and waits (bounded) until done is visible.
  task automatic applyStimulus(input int a, input int b, output int lat, output int busyCycles);
    @(negedge clk);
    start = 1'b1;
    dividend = WIDTH'(a);
    divisor = WIDTH'(b);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busyCycles = 0;
    while (!done && lat < 20) begin
      if (busy) busyCycles++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout %0d/%0d: got no done expected done", a, b);
    end
  endtask

  task automatic waitDone(output int c);
    int k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_done: got no done expected done");
    end
    c = cycle;
  endtask

  task automatic checkResult(input string name, input int q, input int r, input int z);
    checkOutput({name, "_q"}, int'(quotient), q);
    checkOutput({name, "_r"}, int'(remainder), r);
    checkOutput({name, "_z"}, int'(div_by_zero), z);
  endtask

  initial begin
    int lat, bc, q, r, z, c1, c2, dc0, a, b;

    vecs[0] = '{a: 13, b: 3,  q: 4,  r: 1, z: 0};
    vecs[1] = '{a: 5,  b: 0,  q: 15, r: 5, z: 1};
    vecs[2] = '{a: 3,  b: 7,  q: 0,  r: 3, z: 0};
    vecs[3] = '{a: 15, b: 1,  q: 15, r: 0, z: 0};
    vecs[4] = '{a: 0,  b: 5,  q: 0,  r: 0, z: 0};
    vecs[5] = '{a: 15, b: 15, q: 1,  r: 0, z: 0};

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkResult("reset", 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, lat, bc);
      checkOutput($sformatf("vec%0d_latency", i), lat, WIDTH + 1);
      checkOutput($sformatf("vec%0d_busy_cycles", i), bc, WIDTH);
      checkResult($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].z);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_width", i), int'(done), 0);
      checkOutput($sformatf("vec%0d_hold_q", i), int'(quotient), vecs[i].q);
    end

    // Start pulsed during CALC must be ignored.
    dc0 = doneCount;
    @(negedge clk);
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd15; divisor = 4'd15;
    @(negedge clk);
    start = 1'b0;
    waitDone(c1);
    checkResult("ignore", 4, 1, 0);
    repeat (10) @(negedge clk);
    checkOutput("ignore_done_pulses", doneCount - dc0, 1);

    // Start held high: back-to-back operations.
    @(negedge clk);
    start = 1'b1; dividend = 4'd12; divisor = 4'd4;
    @(negedge clk);
    dividend = 4'd7; divisor = 4'd2;
    waitDone(c1);
    checkResult("b2b_first", 3, 0, 0);
    @(negedge clk);
    start = 1'b0;
    waitDone(c2);
    checkResult("b2b_second", 3, 1, 0);
    checkOutput("b2b_spacing", c2 - c1, WIDTH + 1);

    // Reset during the third CALC cycle aborts the operation.
    repeat (2) @(negedge clk);
    dc0 = doneCount;
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkResult("abort", 0, 0, 0);
    repeat (4) @(negedge clk);
    checkOutput("abort_no_done", doneCount - dc0, 0);
    rst_n = 1'b1;
    applyStimulus(14, 3, lat, bc);
    checkResult("after_abort", 4, 2, 0);

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        applyStimulus(x, y, lat, bc);
        refDiv(x, y, q, r, z);
        checkResult($sformatf("sweep_%0d_%0d", x, y), q, r, z);
      end
    end

    repeat (40) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(a, b, lat, bc);
      refDiv(a, b, q, r, z);
      checkOutput($sformatf("rand_%0d_%0d_latency", a, b), lat, WIDTH + 1);
      checkResult($sformatf("rand_%0d_%0d", a, b), q, r, z);
    end

    checkOutput("busy_done_overlap", overlapCount, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
